// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the core's data memory.
// Port 0 is the core load/store port, port 1 the debug/DMA port. One request
// is accepted at a time, checked for alignment and range, and either rejected
// with an error response or sequenced through ISSUE/WAIT/RESP to absorb the
// memory's one-cycle registered read latency.
//
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin arbitration.
// Without it, port 0 has fixed priority over port 1.
//
// Handshake: a request transfers in a cycle where req_valid && req_ready.
// req_ready is high only in IDLE and only for the arbitration winner.
// Responses are a one-cycle rsp_valid pulse with no backpressure.
module dmem_arbiter #(
  parameter int MEM_BYTES = 256,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [31:0]       p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [31:0]       p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Highest word-aligned byte address; compared against the full 32-bit address.
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  state_t            state;
  logic              hold_we;
  logic              hold_id;
  logic              gnt0;
  logic              gnt1;
  logic              hs;
  logic              sel;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              illegal;

`ifdef DMEM_ARB_RR_EN
  // Port that received the most recent grant; reset to 1 so port 0 wins first.
  logic last_gnt;

  // Round-robin: on contention, grant the port that was not granted last.
  always_comb begin
    gnt1 = p1_req_valid && (!p0_req_valid || !last_gnt);
    gnt0 = p0_req_valid && !gnt1;
  end

  // Pointer advances on every handshake, error requests included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (hs) begin
      last_gnt <= sel;
    end
  end
`else
  // Fixed priority: port 0 always beats port 1.
  always_comb begin
    gnt0 = p0_req_valid;
    gnt1 = p1_req_valid && !p0_req_valid;
  end
`endif

  // Ready is combinational; held low while reset is asserted so it reads 0 immediately.
  assign p0_req_ready = rst_n && (state == S_IDLE) && gnt0;
  assign p1_req_ready = rst_n && (state == S_IDLE) && gnt1;
  assign hs           = p0_req_ready || p1_req_ready;
  assign sel          = p1_req_ready;
  assign dbg_state    = state;

  // Mux the accepted request and classify its address.
  always_comb begin
    sel_we    = sel ? p1_req_we    : p0_req_we;
    sel_addr  = sel ? p1_req_addr  : p0_req_addr;
    sel_wdata = sel ? p1_req_wdata : p0_req_wdata;
    illegal   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
  end

  // Sequencer FSM with registered strobes and responses. mem_addr/mem_wdata
  // double as the address/data hold registers and keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      hold_we      <= 1'b0;
      hold_id      <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_err   <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_err   <= 1'b0;
      p1_rsp_rdata <= '0;
    end else begin
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_err   <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_err   <= 1'b0;
      p1_rsp_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            hold_we <= sel_we;
            hold_id <= sel;
            if (illegal) begin
              // Rejected requests never touch the memory interface.
              state <= S_RESP;
              if (sel) begin
                p1_rsp_valid <= 1'b1;
                p1_rsp_err   <= 1'b1;
              end else begin
                p0_rsp_valid <= 1'b1;
                p0_rsp_err   <= 1'b1;
              end
            end else begin
              state     <= S_ISSUE;
              mem_read  <= !sel_we;
              mem_write <= sel_we;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Read data from the memory is valid during this cycle.
          state <= S_RESP;
          if (hold_id) begin
            p1_rsp_valid <= 1'b1;
            p1_rsp_rdata <= hold_we ? '0 : mem_rdata;
          end else begin
            p0_rsp_valid <= 1'b1;
            p0_rsp_rdata <= hold_we ? '0 : mem_rdata;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: cycle-by-cycle vector table for dmem_arbiter plus
// hand-written sequences for reset during ISSUE and read-back.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] mem[64];

  typedef struct {
    logic        p0v, p0we;
    logic [31:0] p0a, p0w;
    logic        p1v, p1we;
    logic [31:0] p1a, p1w;
    logic [1:0]  rdy, rv, err;
    logic [31:0] rd0, rd1;
    logic        mr, mw;
    logic [31:0] ma, mwd;
  } vec_t;

  vec_t vq[$];

  dmem_arbiter #(.MEM_BYTES(256), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Data memory model with registered read; not affected by the arbiter's reset.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end

  function automatic vec_t row(
    input logic p0v, input logic p0we, input logic [31:0] p0a, input logic [31:0] p0w,
    input logic p1v, input logic p1we, input logic [31:0] p1a, input logic [31:0] p1w,
    input logic [1:0] rdy, input logic [1:0] rv, input logic [1:0] err,
    input logic [31:0] rd0, input logic [31:0] rd1,
    input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] mwd);
    vec_t v;
    v.p0v = p0v; v.p0we = p0we; v.p0a = p0a; v.p0w = p0w;
    v.p1v = p1v; v.p1we = p1we; v.p1a = p1a; v.p1w = p1w;
    v.rdy = rdy; v.rv = rv; v.err = err; v.rd0 = rd0; v.rd1 = rd1;
    v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    logic ok;
    @(posedge clk); #1;
    p0_req_valid = v.p0v; p0_req_we = v.p0we; p0_req_addr = v.p0a; p0_req_wdata = v.p0w;
    p1_req_valid = v.p1v; p1_req_we = v.p1we; p1_req_addr = v.p1a; p1_req_wdata = v.p1w;
    @(negedge clk);
    n_vec++;
    ok = ({p1_req_ready, p0_req_ready} === v.rdy) && ({p1_rsp_valid, p0_rsp_valid} === v.rv) &&
         ({p1_rsp_err, p0_rsp_err} === v.err) && (p0_rsp_rdata === v.rd0) &&
         (p1_rsp_rdata === v.rd1) && (mem_read === v.mr) && (mem_write === v.mw) &&
         (mem_addr === v.ma) && (mem_wdata === v.mwd);
    if (!ok) begin
      n_fail++;
      $display("FAIL vec %0d: got rdy=%b rv=%b err=%b rd0=%h rd1=%h mr=%b mw=%b ma=%h mwd=%h; expected rdy=%b rv=%b err=%b rd0=%h rd1=%h mr=%b mw=%b ma=%h mwd=%h",
               i, {p1_req_ready, p0_req_ready}, {p1_rsp_valid, p0_rsp_valid},
               {p1_rsp_err, p0_rsp_err}, p0_rsp_rdata, p1_rsp_rdata, mem_read, mem_write,
               mem_addr, mem_wdata, v.rdy, v.rv, v.err, v.rd0, v.rd1, v.mr, v.mw, v.ma, v.mwd);
    end
  endtask

  // Port 0 read with bounded wait; expected data comes from exp_q.
  task automatic do_read(input logic [31:0] addr);
    int lat;
    logic [31:0] exp;
    @(posedge clk); #1;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = addr; p0_req_wdata = '0;
    @(negedge clk);
    check("rd_ready", 64'(p0_req_ready), 64'd1);
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (p0_rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    exp = exp_q.pop_front();
    if (lat == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL rd_timeout: got no rsp_valid in 8 cycles, expected data %h", exp);
    end else begin
      check("rd_latency", 64'(lat), 64'd3);
      check("rd_data", {31'd0, p0_rsp_err, p0_rsp_rdata}, {31'd0, 1'b0, exp});
    end
  endtask

  initial begin
    logic        w;
    logic [31:0] pma;
    logic [31:0] cma;
    logic [31:0] dat;
    logic        seen;
    n_vec  = 0;
    n_fail = 0;

    // Cycle table: one row per clock, inputs and the outputs seen mid-cycle.
    // Write 0x10 then read it back on port 0.
    vq.push_back(row(1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 2'b01,2'b00,2'b00,0,0, 0,0,32'h0,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 0,1,32'h10,32'hDEADBEEF));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 0,0,32'h10,32'hDEADBEEF));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b01,2'b00,0,0, 0,0,32'h10,32'hDEADBEEF));
    vq.push_back(row(1,0,32'h10,0, 0,0,0,0, 2'b01,2'b00,2'b00,0,0, 0,0,32'h10,32'hDEADBEEF));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 1,0,32'h10,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 0,0,32'h10,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b01,2'b00,32'hDEADBEEF,0, 0,0,32'h10,32'h0));
    // Port 1 misaligned read, then out-of-range read held through the RESP cycle.
    vq.push_back(row(0,0,0,0, 1,0,32'h13,0, 2'b10,2'b00,2'b00,0,0, 0,0,32'h10,32'h0));
    vq.push_back(row(0,0,0,0, 1,0,32'h100,0, 2'b00,2'b10,2'b10,0,0, 0,0,32'h10,32'h0));
    vq.push_back(row(0,0,0,0, 1,0,32'h100,0, 2'b10,2'b00,2'b00,0,0, 0,0,32'h10,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b10,2'b10,0,0, 0,0,32'h10,32'h0));
    // Top legal address 0xFC: write then read.
    vq.push_back(row(1,1,32'hFC,32'h11223344, 0,0,0,0, 2'b01,2'b00,2'b00,0,0, 0,0,32'h10,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 0,1,32'hFC,32'h11223344));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 0,0,32'hFC,32'h11223344));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b01,2'b00,0,0, 0,0,32'hFC,32'h11223344));
    vq.push_back(row(1,0,32'hFC,0, 0,0,0,0, 2'b01,2'b00,2'b00,0,0, 0,0,32'hFC,32'h11223344));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 1,0,32'hFC,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 0,0,32'hFC,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b01,2'b00,32'h11223344,0, 0,0,32'hFC,32'h0));
    // Port 0 read of 0x04; port 1 raises valid mid-transaction and waits for IDLE.
    vq.push_back(row(1,0,32'h04,0, 0,0,0,0, 2'b01,2'b00,2'b00,0,0, 0,0,32'hFC,32'h0));
    vq.push_back(row(0,0,0,0, 1,0,32'h08,0, 2'b00,2'b00,2'b00,0,0, 1,0,32'h04,32'h0));
    vq.push_back(row(0,0,0,0, 1,0,32'h08,0, 2'b00,2'b00,2'b00,0,0, 0,0,32'h04,32'h0));
    vq.push_back(row(0,0,0,0, 1,0,32'h08,0, 2'b00,2'b01,2'b00,32'hA0000001,0, 0,0,32'h04,32'h0));
    vq.push_back(row(0,0,0,0, 1,0,32'h08,0, 2'b10,2'b00,2'b00,0,0, 0,0,32'h04,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 1,0,32'h08,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00,0,0, 0,0,32'h08,32'h0));
    vq.push_back(row(0,0,0,0, 0,0,0,0, 2'b00,2'b10,2'b00,0,32'hA0000002, 0,0,32'h08,32'h0));
    // Both ports valid for four transactions: p0 reads 0x0, p1 reads 0xC.
    pma = 32'h08;
    for (int t = 0; t < 4; t++) begin
`ifdef DMEM_ARB_RR_EN
      w = (t % 2 == 1);
`else
      w = 1'b0;
`endif
      cma = w ? 32'h0C : 32'h00;
      dat = w ? 32'hA0000003 : 32'hA0000000;
      vq.push_back(row(1,0,0,0, 1,0,32'h0C,0, w ? 2'b10 : 2'b01,2'b00,2'b00,0,0, 0,0,pma,32'h0));
      vq.push_back(row(1,0,0,0, 1,0,32'h0C,0, 2'b00,2'b00,2'b00,0,0, 1,0,cma,32'h0));
      vq.push_back(row(1,0,0,0, 1,0,32'h0C,0, 2'b00,2'b00,2'b00,0,0, 0,0,cma,32'h0));
      vq.push_back(row(1,0,0,0, 1,0,32'h0C,0, 2'b00,w ? 2'b10 : 2'b01,2'b00,
                       w ? 32'h0 : dat, w ? dat : 32'h0, 0,0,cma,32'h0));
      pma = cma;
    end

    // Reset state: requests pending while reset is held must see ready = 0.
    drive_idle();
    rst_n = 1'b0;
    p0_req_valid = 1'b1;
    p1_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {56'd0, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid,
                        p0_rsp_err, p1_rsp_err, mem_read, mem_write}, 64'd0);
    check("reset_mem", {mem_addr, mem_wdata}, 64'd0);
    check("reset_rdata", {p0_rsp_rdata, p1_rsp_rdata}, 64'd0);
    drive_idle();
    rst_n = 1'b1;

    foreach (vq[i]) apply_vec(i, vq[i]);

    // Reset asserted mid-ISSUE of a write to 0x20: write dropped, no response.
    @(posedge clk); #1;
    drive_idle();
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'h20; p0_req_wdata = 32'hAAAA5555;
    @(negedge clk);
    check("rst_hs_ready", 64'(p0_req_ready), 64'd1);
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    @(negedge clk);
    check("rst_issue_strobe", {31'd0, mem_write, mem_addr}, {31'd0, 1'b1, 32'h20});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {56'd0, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid,
                            p0_rsp_err, p1_rsp_err, mem_read, mem_write}, 64'd0);
    check("rst_async_mem", {mem_addr, mem_wdata}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | p0_rsp_valid | p1_rsp_valid;
    end
    check("rst_no_rsp", 64'(seen), 64'd0);
    exp_q.push_back(32'hA0000008);
    do_read(32'h20);
    exp_q.push_back(32'hDEADBEEF);
    do_read(32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
